mano_io_device: RTL and testbench

//  External terminal for the Mano basic computer I/O path: the device end of the INPR/FGI and OUTR/FGO handshakes.

---
 rtl/mano_io_pkg.sv | 6 +
 rtl/mano_io_if.sv | 26 ++
 rtl/mano_io_fifo.sv | 39 +++
 rtl/mano_io_device.sv | 69 ++++++
 tb/tb_mano_io_device.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mano_io_pkg.sv
// mano_io_pkg: shared defaults and FSM state encodings for the Mano I/O terminal
package mano_io_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {IN_EMPTY, IN_FULL} in_state_t;
  typedef enum logic [1:0] {OUT_READY, OUT_BUSY, OUT_SEND} out_state_t;
endpackage

// File: rtl/mano_io_if.sv
// mano_io_if: CPU and host handshake signals of the Mano I/O terminal
interface mano_io_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [DATA_W-1:0] inpr;
  logic              fgi;
  logic              cpu_inp;
  logic [DATA_W-1:0] outr;
  logic              cpu_out;
  logic              fgo;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic              ien;
  logic              irq;
  logic              err;
  modport master (
    output host_in_data, host_in_valid, cpu_inp, outr, cpu_out, host_out_ready, ien,
    input  host_in_ready, inpr, fgi, fgo, host_out_data, host_out_valid, irq, err
  );
  modport slave (
    input  host_in_data, host_in_valid, cpu_inp, outr, cpu_out, host_out_ready, ien,
    output host_in_ready, inpr, fgi, fgo, host_out_data, host_out_valid, irq, err
  );
endinterface

// File: rtl/mano_io_fifo.sv
// io_fifo: synchronous FIFO with guarded push/pop and same-cycle push+pop
module io_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr] <= din;
        wr      <= wr + 1'b1;
      end
      if (pop_ok) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/mano_io_device.sv
// mano_io_device: device end of the Mano INPR/FGI and OUTR/FGO handshakes with interrupt request
module mano_io_device
  import mano_io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_DELAY  = 3
) (
  input logic      clk,
  input logic      rst,
  mano_io_if.slave io
);
  localparam int CW = OUT_DELAY > 1 ? $clog2(OUT_DELAY) : 1;
  in_state_t   in_st;
  out_state_t  out_st;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] head;
  logic              full, empty, pop;
  assign pop = in_st == IN_EMPTY && !empty;
  io_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io.host_in_valid),
    .pop   (pop),
    .din   (io.host_in_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign io.host_in_ready  = !full;
  assign io.fgi            = in_st == IN_FULL;
  assign io.fgo            = out_st == OUT_READY;
  assign io.host_out_valid = out_st == OUT_SEND;
  assign io.irq            = io.ien & (io.fgi | io.fgo);
  // A consumed byte leaves fgi low for one cycle before the next head is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      in_st   <= IN_EMPTY;
      io.inpr <= '0;
    end else if (pop) begin
      in_st   <= IN_FULL;
      io.inpr <= head;
    end else if (in_st == IN_FULL && io.cpu_inp) begin
      in_st <= IN_EMPTY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_st           <= OUT_READY;
      cnt              <= '0;
      io.host_out_data <= '0;
    end else begin
      case (out_st)
        OUT_READY: if (io.cpu_out) begin
          out_st           <= OUT_BUSY;
          cnt              <= CW'(OUT_DELAY - 1);
          io.host_out_data <= io.outr;
        end
        OUT_BUSY: if (cnt == '0) out_st <= OUT_SEND; else cnt <= cnt - 1'b1;
        OUT_SEND: if (io.host_out_ready) out_st <= OUT_READY;
        default:  out_st <= OUT_READY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) io.err <= 1'b0;
    else if ((io.cpu_inp && in_st == IN_EMPTY) || (io.cpu_out && out_st != OUT_READY)) io.err <= 1'b1;
  end
endmodule

// File: tb/tb_mano_io_device.sv
// tb_mano_io_device: directed scenarios plus randomized run against a queue/timestamp reference model
module tb_mano_io_device;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  mano_io_if #(.DATA_W(8)) io ();
  mano_io_device #(.DATA_W(8), .FIFO_DEPTH(4), .OUT_DELAY(3)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    io.host_in_data   = '0;
    io.host_in_valid  = 1'b0;
    io.cpu_inp        = 1'b0;
    io.outr           = '0;
    io.cpu_out        = 1'b0;
    io.host_out_ready = 1'b0;
    io.ien            = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++; if (io.fgi !== 1'b0) begin errors++; $display("FAIL reset_fgi got=%b want=0", io.fgi); end
    checks++; if (io.fgo !== 1'b1) begin errors++; $display("FAIL reset_fgo got=%b want=1", io.fgo); end
    checks++; if (io.host_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", io.host_in_ready); end
    checks++; if (io.host_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", io.host_out_valid); end
    checks++; if (io.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", io.err); end
    checks++; if (io.inpr !== 8'h00) begin errors++; $display("FAIL reset_inpr got=%h want=00", io.inpr); end
    checks++; if (io.host_out_data !== 8'h00) begin errors++; $display("FAIL reset_odata got=%h want=00", io.host_out_data); end
    checks++; if (io.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", io.irq); end
  endtask
  task automatic test_input_single();
    io.host_in_data  = 8'h41;
    io.host_in_valid = 1'b1;
    tick();
    io.host_in_valid = 1'b0;
    checks++; if (io.fgi !== 1'b0) begin errors++; $display("FAIL single_fgi_early got=%b want=0", io.fgi); end
    tick();
    checks++; if (io.fgi !== 1'b1 || io.inpr !== 8'h41) begin errors++; $display("FAIL single_load got=%b/%h want=1/41", io.fgi, io.inpr); end
    io.ien = 1'b1;
    #1;
    checks++; if (io.irq !== 1'b1) begin errors++; $display("FAIL single_irq_on got=%b want=1", io.irq); end
    io.ien = 1'b0;
    #1;
    checks++; if (io.irq !== 1'b0) begin errors++; $display("FAIL single_irq_off got=%b want=0", io.irq); end
    io.cpu_inp = 1'b1;
    tick();
    io.cpu_inp = 1'b0;
    checks++; if (io.fgi !== 1'b0 || io.inpr !== 8'h41) begin errors++; $display("FAIL single_consume got=%b/%h want=0/41", io.fgi, io.inpr); end
    checks++; if (io.err !== 1'b0) begin errors++; $display("FAIL single_err got=%b want=0", io.err); end
  endtask
  task automatic test_fifo_fill();
    io.host_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      io.host_in_data = 8'(8'h10 + i);
      tick();
    end
    io.host_in_data = 8'h99;
    checks++; if (io.host_in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b want=0", io.host_in_ready); end
    checks++; if (io.inpr !== 8'h10 || io.fgi !== 1'b1) begin errors++; $display("FAIL fill_head got=%h/%b want=10/1", io.inpr, io.fgi); end
    tick();
    io.host_in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      io.cpu_inp = 1'b1;
      tick();
      io.cpu_inp = 1'b0;
      checks++; if (io.fgi !== 1'b0) begin errors++; $display("FAIL fill_gap%0d got=%b want=0", i, io.fgi); end
      tick();
      checks++; if (io.fgi !== 1'b1 || io.inpr !== 8'(8'h10 + i)) begin errors++; $display("FAIL fill_byte%0d got=%b/%h want=1/%h", i, io.fgi, io.inpr, 8'(8'h10 + i)); end
    end
    io.cpu_inp = 1'b1;
    tick();
    io.cpu_inp = 1'b0;
    tick();
    checks++; if (io.fgi !== 1'b0 || io.host_in_ready !== 1'b1) begin errors++; $display("FAIL fill_drained got=%b/%b want=0/1", io.fgi, io.host_in_ready); end
    checks++; if (io.err !== 1'b0) begin errors++; $display("FAIL fill_err got=%b want=0", io.err); end
  endtask
  task automatic test_output();
    io.host_out_ready = 1'b1;
    io.outr           = 8'h5A;
    io.cpu_out        = 1'b1;
    tick();
    io.cpu_out = 1'b0;
    checks++; if (io.fgo !== 1'b0 || io.host_out_valid !== 1'b0 || io.host_out_data !== 8'h5A) begin errors++; $display("FAIL out_busy got=%b/%b/%h want=0/0/5a", io.fgo, io.host_out_valid, io.host_out_data); end
    io.outr    = 8'hA5;
    io.cpu_out = 1'b1;
    tick();
    io.cpu_out = 1'b0;
    checks++; if (io.err !== 1'b1 || io.host_out_data !== 8'h5A) begin errors++; $display("FAIL out_busy_write got=%b/%h want=1/5a", io.err, io.host_out_data); end
    tick();
    checks++; if (io.host_out_valid !== 1'b0) begin errors++; $display("FAIL out_early got=%b want=0", io.host_out_valid); end
    tick();
    checks++; if (io.host_out_valid !== 1'b1 || io.host_out_data !== 8'h5A) begin errors++; $display("FAIL out_send got=%b/%h want=1/5a", io.host_out_valid, io.host_out_data); end
    tick();
    checks++; if (io.host_out_valid !== 1'b0 || io.fgo !== 1'b1) begin errors++; $display("FAIL out_done got=%b/%b want=0/1", io.host_out_valid, io.fgo); end
    io.host_out_ready = 1'b0;
  endtask
  task automatic test_backpressure();
    io.outr    = 8'h3C;
    io.cpu_out = 1'b1;
    tick();
    io.cpu_out = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (io.host_out_valid !== 1'b1 || io.host_out_data !== 8'h3C || io.fgo !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got=%b/%h/%b want=1/3c/0", i, io.host_out_valid, io.host_out_data, io.fgo); end
    end
    io.host_out_ready = 1'b1;
    tick();
    io.host_out_ready = 1'b0;
    checks++; if (io.host_out_valid !== 1'b0 || io.fgo !== 1'b1) begin errors++; $display("FAIL bp_release got=%b/%b want=0/1", io.host_out_valid, io.fgo); end
  endtask
  task automatic test_simultaneous_reset();
    io.host_in_data  = 8'h77;
    io.host_in_valid = 1'b1;
    tick();
    io.host_in_valid = 1'b0;
    tick();
    io.host_in_data  = 8'h88;
    io.host_in_valid = 1'b1;
    io.cpu_inp       = 1'b1;
    io.outr          = 8'h55;
    io.cpu_out       = 1'b1;
    tick();
    idle_inputs();
    checks++; if (io.fgi !== 1'b0 || io.inpr !== 8'h77 || io.fgo !== 1'b0 || io.host_out_data !== 8'h55) begin errors++; $display("FAIL simul_edge got=%b/%h/%b/%h want=0/77/0/55", io.fgi, io.inpr, io.fgo, io.host_out_data); end
    tick();
    checks++; if (io.fgi !== 1'b1 || io.inpr !== 8'h88) begin errors++; $display("FAIL simul_next got=%b/%h want=1/88", io.fgi, io.inpr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (io.fgi !== 1'b0 || io.inpr !== 8'h00 || io.fgo !== 1'b1 || io.host_out_valid !== 1'b0 || io.host_out_data !== 8'h00 || io.err !== 1'b0 || io.host_in_ready !== 1'b1) begin errors++; $display("FAIL simul_reset got=%b/%h/%b/%b/%h/%b/%b want=0/00/1/0/00/0/1", io.fgi, io.inpr, io.fgo, io.host_out_valid, io.host_out_data, io.err, io.host_in_ready); end
    io.host_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (io.host_out_valid !== 1'b0 || io.fgi !== 1'b0) begin errors++; $display("FAIL simul_quiet%0d got=%b/%b want=0/0", i, io.host_out_valid, io.fgi); end
    end
    io.host_out_ready = 1'b0;
  endtask
  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] m_inpr, m_out;
    bit m_fgi, m_fgo, m_val, m_err, was_full;
    int send_at;
    idle_inputs();
    do_reset();
    m_inpr = 8'h00; m_out = 8'h00;
    m_fgi = 0; m_fgo = 1; m_val = 0; m_err = 0;
    send_at = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (io.fgi !== m_fgi || io.inpr !== m_inpr) begin errors++; $display("FAIL rnd_in c%0d got=%b/%h want=%b/%h", cyc, io.fgi, io.inpr, m_fgi, m_inpr); end
      checks++; if (io.fgo !== m_fgo || io.host_out_valid !== m_val || io.host_out_data !== m_out) begin errors++; $display("FAIL rnd_out c%0d got=%b/%b/%h want=%b/%b/%h", cyc, io.fgo, io.host_out_valid, io.host_out_data, m_fgo, m_val, m_out); end
      checks++; if (io.host_in_ready !== (q.size() < 4) || io.err !== m_err) begin errors++; $display("FAIL rnd_flags c%0d got=%b/%b want=%b/%b", cyc, io.host_in_ready, io.err, q.size() < 4, m_err); end
      checks++; if (io.irq !== (io.ien & (m_fgi | m_fgo))) begin errors++; $display("FAIL rnd_irq c%0d got=%b want=%b", cyc, io.irq, io.ien & (m_fgi | m_fgo)); end
      io.host_in_valid  = ($urandom_range(0, 2) == 0);
      io.host_in_data   = 8'($urandom);
      io.cpu_inp        = ($urandom_range(0, 3) == 0);
      io.cpu_out        = ($urandom_range(0, 3) == 0);
      io.outr           = 8'($urandom);
      io.host_out_ready = ($urandom_range(0, 1) == 0);
      io.ien            = 1'($urandom);
      if ((io.cpu_inp && !m_fgi) || (io.cpu_out && !m_fgo)) m_err = 1;
      was_full = q.size() == 4;
      if (!m_fgi && q.size() > 0) begin
        m_inpr = q.pop_front();
        m_fgi  = 1;
      end else if (m_fgi && io.cpu_inp) m_fgi = 0;
      if (io.host_in_valid && !was_full) q.push_back(io.host_in_data);
      if (m_fgo && io.cpu_out) begin
        m_fgo   = 0;
        m_out   = io.outr;
        send_at = cyc + 3;
      end else if (!m_fgo && !m_val && cyc == send_at) m_val = 1;
      else if (m_val && io.host_out_ready) begin
        m_val = 0;
        m_fgo = 1;
      end
      tick();
    end
    idle_inputs();
  endtask
  initial begin
    test_reset();
    test_input_single();
    test_fifo_fill();
    test_output();
    test_backpressure();
    test_simultaneous_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
